// File: rtl/match_report_pkg.sv
// Shared defaults and report entry layout for the match reporter.
package match_report_pkg;

  localparam int unsigned NumEngDefault    = 16;
  localparam int unsigned OfsWDefault      = 16;
  localparam int unsigned FifoDepthDefault = 8;
  localparam int unsigned IdWDefault       = $clog2(NumEngDefault);

  typedef struct packed {
    logic [IdWDefault-1:0]  id;
    logic [OfsWDefault-1:0] ofs;
  } rpt_entry_t;

endpackage

// File: rtl/match_report_fifo.sv
// Report FIFO: synchronous, full/empty flags, head held in a register.
module match_report_fifo
  import match_report_pkg::*;
#(
  parameter int unsigned Depth = FifoDepthDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  rpt_entry_t wdata_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output rpt_entry_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  rpt_entry_t      mem_q [Depth];
  rpt_entry_t      head_q, head_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthCnt);
  assign head_o  = head_q;

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    // The write slot equals the new read slot only when the entry being written becomes the head.
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (do_push && (wr_q == rd_d)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/match_report.sv
// Engine match-line reporter: edge detect, pending set, lowest-index push into a report FIFO.
// Optional drop counter output enabled by defining MATCH_REPORT_DROP_CNT_EN.
module match_report
  import match_report_pkg::*;
#(
  parameter int unsigned NUM_ENG    = NumEngDefault,
  parameter int unsigned OFS_W      = OfsWDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sod,
  input  logic                       en,
  input  logic [NUM_ENG-1:0]         match_in,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [$clog2(NUM_ENG)-1:0] rpt_id,
  output logic [OFS_W-1:0]           rpt_ofs,
  output logic                       ovf
`ifdef MATCH_REPORT_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int unsigned IdW = $clog2(NUM_ENG);

  logic [OFS_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NUM_ENG-1:0] match_q, match_d, pend_q, pend_d, new_hits;
  logic [OFS_W-1:0]   ofs_q [NUM_ENG];
  logic [OFS_W-1:0]   ofs_d [NUM_ENG];
  logic               ovf_q, ovf_d;
  logic [IdW-1:0]     sel_idx;
  logic               sel_hit, push_req, push_ok, pop;
  logic               fifo_full, fifo_empty;
  rpt_entry_t         push_entry, head;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_hit = 1'b1;
        sel_idx = IdW'(i);
      end
    end
  end

  // A sod cycle drops what is pending rather than pushing one last entry.
  assign push_req = sel_hit && !sod;
  assign pop      = rpt_valid && rpt_ready;
  assign push_ok  = push_req && (!fifo_full || pop);

  always_comb begin
    push_entry.id  = sel_idx;
    push_entry.ofs = ofs_q[sel_idx];
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    match_d    = match_in;
    pend_d     = pend_q;
    ofs_d      = ofs_q;
    ovf_d      = ovf_q;
    new_hits   = match_in & ~match_q;
    if (sod) begin
      byte_cnt_d = '0;
      match_d    = '0;
      new_hits   = '0;
      pend_d     = '0;
      if (pend_q != '0) begin
        ovf_d = 1'b1;
      end
    end else begin
      if (en && (byte_cnt_q != '1)) begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
      if (push_ok) begin
        pend_d[sel_idx] = 1'b0;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        if (new_hits[i]) begin
          pend_d[i] = 1'b1;
          ofs_d[i]  = byte_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    ofs_q <= ofs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      match_q    <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      match_q    <= match_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef MATCH_REPORT_DROP_CNT_EN
  logic [7:0]  drop_q, drop_d;
  logic [31:0] drop_sum;

  always_comb begin
    drop_sum = 32'(drop_q) + 32'($countones(pend_q));
    drop_d   = drop_q;
    if (sod && (pend_q != '0)) begin
      drop_d = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

  match_report_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_ok),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  assign rpt_valid = !fifo_empty;
  assign rpt_id    = head.id;
  assign rpt_ofs   = head.ofs;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_match_report.sv
// Self-checking bench for match_report: queue-based reference model plus directed scenarios.
module tb_match_report;
  import match_report_pkg::*;

  localparam int NE = 16;

  logic        clk, rst, sod, en, rpt_ready, rpt_valid, ovf;
  logic [15:0] match_in;
  logic [3:0]  rpt_id;
  logic [15:0] rpt_ofs;
`ifdef MATCH_REPORT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  match_report #(
    .NUM_ENG   (16),
    .OFS_W     (16),
    .FIFO_DEPTH(8)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sod      (sod),
    .en       (en),
    .match_in (match_in),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_id   (rpt_id),
    .rpt_ofs  (rpt_ofs),
    .ovf      (ovf)
`ifdef MATCH_REPORT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reports are a queue, pending engines a bit set.
  typedef struct {int id; int ofs;} rep_t;
  rep_t    m_q[$];
  rep_t    m_e;
  int      m_cnt = 0, m_drop = 0, m_lo;
  int      m_ofs[NE];
  bit      m_ovf = 0, m_pop, m_push;
  bit [NE-1:0] m_prev = '0, m_pend = '0, m_new;

  task automatic model_step();
    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_drop = 0; m_ovf = 0; m_prev = '0; m_pend = '0;
      return;
    end
    m_pop  = (m_q.size() != 0) && rpt_ready;
    m_push = 0;
    if (sod) begin
      if (m_pend != '0) begin
        m_ovf  = 1;
        m_drop = m_drop + $countones(m_pend);
        if (m_drop > 255) m_drop = 255;
      end
      m_pend = '0; m_prev = '0; m_cnt = 0;
    end else begin
      m_lo = -1;
      for (int i = 0; i < NE; i++) begin
        if (m_pend[i]) begin m_lo = i; break; end
      end
      if (m_lo >= 0 && (m_q.size() < 8 || m_pop)) begin
        m_push = 1; m_e.id = m_lo; m_e.ofs = m_ofs[m_lo]; m_pend[m_lo] = 0;
      end
      m_new = match_in & ~m_prev;
      for (int i = 0; i < NE; i++) begin
        if (m_new[i]) begin m_pend[i] = 1; m_ofs[i] = m_cnt; end
      end
      m_prev = match_in;
      if (en && m_cnt < 65535) m_cnt++;
    end
    if (m_pop) void'(m_q.pop_front());
    if (m_push) m_q.push_back(m_e);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Delivered reports, for the directed expectations.
  int got_id[$], got_ofs[$];
  initial forever begin
    @(posedge clk);
    if (!rst && rpt_valid === 1'b1 && rpt_ready) begin
      got_id.push_back(int'(rpt_id));
      got_ofs.push_back(int'(rpt_ofs));
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("model_valid", 64'(rpt_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("model_id", 64'(rpt_id), 64'(m_q[0].id));
        chk("model_ofs", 64'(rpt_ofs), 64'(m_q[0].ofs));
      end
      chk("model_ovf", 64'(ovf), 64'(m_ovf));
`ifdef MATCH_REPORT_DROP_CNT_EN
      chk("model_drop", 64'(drop_cnt), 64'(m_drop));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input bit s, input bit e, input logic [15:0] m);
    sod = s; en = e; match_in = m;
    tick();
  endtask

  initial begin
    rst = 1'b1; sod = 0; en = 0; match_in = '0; rpt_ready = 0;
    repeat (3) tick();
    chk("rst_valid", 64'(rpt_valid), 64'd0);
    chk("rst_id", 64'(rpt_id), 64'd0);
    chk("rst_ofs", 64'(rpt_ofs), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Single match at byte 4, latency of two cycles.
    rpt_ready = 1;
    drv(1, 0, 16'h0);
    repeat (4) drv(0, 1, 16'h0);
    drv(0, 1, 16'h0008);
    chk("single_t1_valid", 64'(rpt_valid), 64'd0);
    drv(0, 0, 16'h0008);
    chk("single_t2_valid", 64'(rpt_valid), 64'd1);
    chk("single_id", 64'(rpt_id), 64'd3);
    chk("single_ofs", 64'(rpt_ofs), 64'd4);
    drv(0, 0, 16'h0008);
    chk("single_t3_valid", 64'(rpt_valid), 64'd0);

    // Two engines rising together at byte 10.
    drv(1, 0, 16'h0);
    repeat (10) drv(0, 1, 16'h0);
    drv(0, 1, 16'h0084);
    chk("simul_t1_valid", 64'(rpt_valid), 64'd0);
    drv(0, 0, 16'h0084);
    chk("simul_a_id", 64'(rpt_id), 64'd2);
    chk("simul_a_ofs", 64'(rpt_ofs), 64'd10);
    drv(0, 0, 16'h0084);
    chk("simul_b_id", 64'(rpt_id), 64'd7);
    chk("simul_b_ofs", 64'(rpt_ofs), 64'd10);
    drv(0, 0, 16'h0084);
    chk("simul_end_valid", 64'(rpt_valid), 64'd0);

    // Backpressure: ten engines, eight fit in the FIFO.
    rpt_ready = 0;
    drv(1, 0, 16'h0);
    repeat (3) drv(0, 1, 16'h0);
    drv(0, 0, 16'h03FF);
    repeat (12) drv(0, 0, 16'h03FF);
    chk("bp_hold_valid", 64'(rpt_valid), 64'd1);
    chk("bp_hold_id", 64'(rpt_id), 64'd0);
    chk("bp_hold_ofs", 64'(rpt_ofs), 64'd3);
    got_id.delete(); got_ofs.delete();
    rpt_ready = 1;
    repeat (15) drv(0, 0, 16'h03FF);
    chk("bp_count", 64'(got_id.size()), 64'd10);
    foreach (got_id[k]) begin
      chk("bp_order_id", 64'(got_id[k]), 64'(k));
      chk("bp_order_ofs", 64'(got_ofs[k]), 64'd3);
    end
    chk("bp_ovf", 64'(ovf), 64'd0);

    // Loss at sod with a full FIFO and two pending engines.
    rpt_ready = 0;
    drv(1, 0, 16'h0);
    repeat (2) drv(0, 1, 16'h0);
    drv(0, 1, 16'h03FF);
    repeat (12) drv(0, 0, 16'h03FF);
    chk("loss_pre_ovf", 64'(ovf), 64'd0);
    drv(1, 0, 16'h0);
    chk("loss_ovf", 64'(ovf), 64'd1);
`ifdef MATCH_REPORT_DROP_CNT_EN
    chk("loss_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    got_id.delete(); got_ofs.delete();
    rpt_ready = 1;
    repeat (12) drv(0, 0, 16'h0);
    chk("loss_count", 64'(got_id.size()), 64'd8);
    foreach (got_id[k]) begin
      chk("loss_id", 64'(got_id[k]), 64'(k));
      chk("loss_ofs", 64'(got_ofs[k]), 64'd2);
    end
    chk("loss_end_valid", 64'(rpt_valid), 64'd0);

    // Sticky engine held for 50 cycles, then a fresh stream.
    got_id.delete(); got_ofs.delete();
    drv(1, 0, 16'h0);
    repeat (3) drv(0, 1, 16'h0);
    repeat (50) drv(0, 1, 16'h0020);
    chk("sticky_count", 64'(got_id.size()), 64'd1);
    if (got_id.size() > 0) begin
      chk("sticky_id", 64'(got_id[0]), 64'd5);
      chk("sticky_ofs", 64'(got_ofs[0]), 64'd3);
    end
    drv(1, 0, 16'h0);
    repeat (2) drv(0, 1, 16'h0);
    repeat (7) drv(0, 1, 16'h0020);
    chk("sticky2_count", 64'(got_id.size()), 64'd2);
    if (got_id.size() > 1) begin
      chk("sticky2_id", 64'(got_id[1]), 64'd5);
      chk("sticky2_ofs", 64'(got_ofs[1]), 64'd2);
    end

    // Asynchronous reset while a report is waiting.
    rpt_ready = 0;
    drv(1, 0, 16'h0);
    drv(0, 1, 16'h0);
    drv(0, 1, 16'h0002);
    repeat (4) drv(0, 0, 16'h0002);
    chk("ar_pre_valid", 64'(rpt_valid), 64'd1);
    chk("ar_pre_id", 64'(rpt_id), 64'd1);
    chk("ar_pre_ofs", 64'(rpt_ofs), 64'd1);
    chk("ar_pre_ovf", 64'(ovf), 64'd1);
    #1;
    rst = 1'b1; sod = 0; en = 0; match_in = '0;
    #1;
    chk("ar_valid", 64'(rpt_valid), 64'd0);
    chk("ar_id", 64'(rpt_id), 64'd0);
    chk("ar_ofs", 64'(rpt_ofs), 64'd0);
    chk("ar_ovf", 64'(ovf), 64'd0);
`ifdef MATCH_REPORT_DROP_CNT_EN
    chk("ar_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    got_id.delete(); got_ofs.delete();
    rpt_ready = 1;
    repeat (6) drv(0, 0, 16'h0);
    chk("ar_no_report", 64'(got_id.size()), 64'd0);
    chk("ar_post_valid", 64'(rpt_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_report.md
MATCH_REPORT -- requirements
Module: match_report

Interface
REQ-001 SHALL have parameter NUM_ENG, default 16: number of engine match lines monitored.
REQ-002 SHALL have parameter OFS_W, default 16: byte-offset width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: report FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port sod, input, 1: start-of-data; the same signal that clears the engines.
REQ-007 SHALL have port en, input, 1: byte-accept strobe shared with the engines.
REQ-008 SHALL have port match_in, input, NUM_ENG: engine out lines, bit i = engine i.
REQ-009 SHALL have ports rpt_valid (output, 1) and rpt_ready (input, 1): report handshake.
REQ-010 SHALL have port rpt_id, output, clog2(NUM_ENG): matching engine index.
REQ-011 SHALL have port rpt_ofs, output, OFS_W: byte count at match detection.
REQ-012 SHALL have port ovf, output, 1: sticky loss flag.

Function
REQ-013 SHALL keep byte_cnt: cleared to 0 on a sod cycle (sod wins over en); otherwise +1 on each en=1 cycle; saturates at all-ones, with no wrap.
REQ-014 SHALL register match_in into match_q each cycle; on a sod cycle match_q SHALL be cleared.
REQ-015 SHALL detect new = match_in & ~match_q, ignored on sod cycles; engine outputs are sticky, so each engine reports at most once per stream.
REQ-016 SHALL, for each set bit of new, set pend[i] and capture ofs[i] = byte_cnt (pre-increment value of that cycle).
REQ-017 SHALL, each cycle with pend nonzero and the FIFO not full, push {lowest set index i, ofs[i]} and clear pend[i]; one push per cycle maximum.
REQ-018 SHALL allow a push and a pop in the same cycle when the FIFO is full.
REQ-019 SHALL allow a bit that is both newly set and selected in one cycle, with latency: edge cycle t -> pend at t+1 -> FIFO push at t+1 -> rpt_valid at t+2 at the earliest.
REQ-020 SHALL present the FIFO head on rpt_id/rpt_ofs with rpt_valid=1 while non-empty; pop on rpt_valid & rpt_ready; outputs stable while valid and not ready.
REQ-021 SHALL NOT flush the FIFO on sod; entries from the previous stream remain deliverable.
REQ-022 SHALL, on sod with pend nonzero, clear pend and set ovf=1; ovf clears only on rst.
REQ-023 SHALL be unaffected by en for detection and push logic; en gates only byte_cnt.

Reset
REQ-024 SHALL, on rst, asynchronously set byte_cnt=0, match_q=0, pend=0, FIFO empty, rpt_valid=0, rpt_id=0, rpt_ofs=0, ovf=0.
REQ-025 SHALL drop any in-flight handshake when rst asserts mid-transfer, with no report delivered afterwards.

Configuration
REQ-026 SHALL, with MATCH_REPORT_DROP_CNT_EN defined, add output drop_cnt (8 bits, saturating), incremented by popcount of pend at each sod that clears pending bits, and reset to 0.
REQ-027 SHALL, without MATCH_REPORT_DROP_CNT_EN, have no drop_cnt port or logic; ovf behaviour is unchanged.

Structure
REQ-028 SHALL take the default parameters and the report entry type {id, ofs} from shared package match_report_pkg.
REQ-029 SHALL implement the FIFO as sub-module match_report_fifo (synchronous, full/empty flags, registered head output).
REQ-030 SHALL implement the lowest-index priority encoder combinationally inside match_report.

Verification
REQ-031 SHALL verify a single match: sod, then 5 en bytes; match_in[3] rises on the cycle byte_cnt=4 -> one report id=3, ofs=4; rpt_valid two cycles after the edge.
REQ-032 SHALL verify simultaneous edges: match_in[7] and [2] rise together at byte_cnt=10 -> reports id=2 then id=7, both ofs=10, on consecutive cycles with rpt_ready=1.
REQ-033 SHALL verify backpressure: rpt_ready=0 with 10 engines matching -> 8 FIFO entries and 2 pend bits held; then rpt_ready=1 -> all 10 delivered in index order with no loss, ovf=0.
REQ-034 SHALL verify loss at sod: FIFO full and 2 pend bits set, then sod -> ovf=1, the 8 queued reports still delivered, drop_cnt=2 when enabled.
REQ-035 SHALL verify stickiness: match_in[5] held high for 50 cycles -> exactly one report; after sod and a new rise -> a second report with ofs counted from 0.
REQ-036 SHALL verify async reset: rst asserted mid-stream with rpt_valid=1 -> all outputs 0 in the same cycle without a clock edge.
